// File: rtl/tpu_matmul_engine.sv
// Byte-serial N x N matrix multiply engine: loads A then B, accumulates C = A * B'
// over N compute cycles, then streams post-processed results out MSB first.
module tpu_matmul_engine #(
  parameter int N     = 2,
  parameter int DW    = 8,
  parameter int OUT_W = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  input  logic          cfg_transpose_i,
  input  logic          cfg_signed_i,
  input  logic          cfg_relu_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [7:0]    out_data_o,
  output logic          out_last_o,
  output logic          busy_o
);

  localparam int NN    = N * N;
  localparam int NOPS  = 2 * NN;
  localparam int BPE   = OUT_W / 8;
  localparam int ACC_W = 2 * DW + $clog2(N) + 1;
  localparam int CW    = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam int LW    = $clog2(NOPS);
  localparam int KW    = $clog2(N);
  localparam int EW    = $clog2(NN);
  localparam int BW    = $clog2(BPE);

  localparam logic [LW-1:0] LAST_LOAD = LW'(NOPS - 1);
  localparam logic [KW-1:0] LAST_K    = KW'(N - 1);
  localparam logic [EW-1:0] LAST_ELEM = EW'(NN - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BPE - 1);

  localparam logic [CW-1:0] SMAX = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [CW-1:0] SMIN = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [CW-1:0] UMAX = {{(CW-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [LW-1:0]          loadCnt_q, loadCnt_d;
  logic [KW-1:0]          kCnt_q, kCnt_d;
  logic [EW-1:0]          elemCnt_q, elemCnt_d;
  logic [BW-1:0]          byteCnt_q, byteCnt_d;
  logic                   cfgT_q, cfgT_d, cfgS_q, cfgS_d, cfgR_q, cfgR_d;
  logic [NOPS*DW-1:0]     op_q;
  logic [NN*ACC_W-1:0]    acc_q, acc_d;
  logic                   loadEn;

  logic [DW-1:0]          aByte, bByte;
  logic signed [2*DW-1:0] sProd;
  logic [2*DW-1:0]        uProd;
  logic [ACC_W-1:0]       prod;
  int                     bIdx;

  logic [ACC_W-1:0]       accSel;
  logic [CW-1:0]          ext;
  logic [OUT_W-1:0]       res;

  always_comb begin
    state_d   = state_q;
    loadCnt_d = loadCnt_q;
    kCnt_d    = kCnt_q;
    elemCnt_d = elemCnt_q;
    byteCnt_d = byteCnt_q;
    cfgT_d    = cfgT_q;
    cfgS_d    = cfgS_q;
    cfgR_d    = cfgR_q;
    acc_d     = acc_q;
    loadEn    = 1'b0;
    aByte     = '0;
    bByte     = '0;
    sProd     = '0;
    uProd     = '0;
    prod      = '0;
    bIdx      = 0;
    case (state_q)
      LOAD: begin
        if (in_valid_i) begin
          loadEn = 1'b1;
          if (loadCnt_q == '0) begin
            cfgT_d = cfg_transpose_i;
            cfgS_d = cfg_signed_i;
            cfgR_d = cfg_relu_i;
          end
          if (loadCnt_q == LAST_LOAD) begin
            loadCnt_d = '0;
            state_d   = COMPUTE;
          end else begin
            loadCnt_d = loadCnt_q + LW'(1);
          end
        end
      end
      COMPUTE: begin
        // Every C[i][j] absorbs one rank-1 term per cycle, indexed by kCnt.
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            aByte = op_q[(i*N + int'(kCnt_q))*DW +: DW];
            bIdx  = cfgT_q ? (NN + j*N + int'(kCnt_q)) : (NN + int'(kCnt_q)*N + j);
            bByte = op_q[bIdx*DW +: DW];
            sProd = $signed(aByte) * $signed(bByte);
            uProd = aByte * bByte;
            prod  = cfgS_q ? {{(ACC_W-2*DW){sProd[2*DW-1]}}, sProd}
                           : {{(ACC_W-2*DW){1'b0}}, uProd};
            acc_d[(i*N+j)*ACC_W +: ACC_W] = acc_q[(i*N+j)*ACC_W +: ACC_W] + prod;
          end
        end
        if (kCnt_q == LAST_K) begin
          kCnt_d  = '0;
          state_d = DRAIN;
        end else begin
          kCnt_d = kCnt_q + KW'(1);
        end
      end
      DRAIN: begin
        if (out_ready_i) begin
          if (byteCnt_q == LAST_BYTE) begin
            byteCnt_d = '0;
            if (elemCnt_q == LAST_ELEM) begin
              elemCnt_d = '0;
              acc_d     = '0;
              state_d   = LOAD;
            end else begin
              elemCnt_d = elemCnt_q + EW'(1);
            end
          end else begin
            byteCnt_d = byteCnt_q + BW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
    // Abort wins over any handshake happening on the same edge.
    if (clear_i) begin
      state_d   = LOAD;
      loadCnt_d = '0;
      kCnt_d    = '0;
      elemCnt_d = '0;
      byteCnt_d = '0;
      acc_d     = '0;
      loadEn    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= LOAD;
      loadCnt_q <= '0;
      kCnt_q    <= '0;
      elemCnt_q <= '0;
      byteCnt_q <= '0;
      cfgT_q    <= 1'b0;
      cfgS_q    <= 1'b0;
      cfgR_q    <= 1'b0;
      op_q      <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      loadCnt_q <= loadCnt_d;
      kCnt_q    <= kCnt_d;
      elemCnt_q <= elemCnt_d;
      byteCnt_q <= byteCnt_d;
      cfgT_q    <= cfgT_d;
      cfgS_q    <= cfgS_d;
      cfgR_q    <= cfgR_d;
      acc_q     <= acc_d;
      if (loadEn) op_q[int'(loadCnt_q)*DW +: DW] <= in_data_i;
    end
  end

  // ReLU then saturation, evaluated in a width wide enough for both ranges.
  always_comb begin
    accSel = acc_q[int'(elemCnt_q)*ACC_W +: ACC_W];
    ext    = cfgS_q ? {{(CW-ACC_W){accSel[ACC_W-1]}}, accSel}
                    : {{(CW-ACC_W){1'b0}}, accSel};
    if (cfgS_q && cfgR_q && ext[CW-1]) ext = '0;
    if (cfgS_q) begin
      if ($signed(ext) > $signed(SMAX))      res = SMAX[OUT_W-1:0];
      else if ($signed(ext) < $signed(SMIN)) res = SMIN[OUT_W-1:0];
      else                                   res = ext[OUT_W-1:0];
    end else begin
      res = (ext > UMAX) ? UMAX[OUT_W-1:0] : ext[OUT_W-1:0];
    end
  end

  assign in_ready_o  = (state_q == LOAD);
  assign out_valid_o = (state_q == DRAIN);
  assign busy_o      = (state_q == COMPUTE) || (state_q == DRAIN);
  assign out_data_o  = (state_q == DRAIN) ? res[(BPE-1-int'(byteCnt_q))*8 +: 8] : 8'h00;
  assign out_last_o  = (state_q == DRAIN) && (elemCnt_q == LAST_ELEM) && (byteCnt_q == LAST_BYTE);

endmodule

// File: tb/tb_tpu_matmul_engine.sv
// Directed self-checking bench for tpu_matmul_engine (N=2, OUT_W=16): vector table
// plus hand-written backpressure, clear and mid-drain reset sequences.
module tb_tpu_matmul_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       inValid;
  logic       inReady;
  logic [7:0] inData;
  logic       cfgTranspose, cfgSigned, cfgRelu;
  logic       outValid;
  logic       outReady;
  logic [7:0] outData;
  logic       outLast;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tpu_matmul_engine #(.N(2), .DW(8), .OUT_W(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clear_i        (clear),
    .in_valid_i     (inValid),
    .in_ready_o     (inReady),
    .in_data_i      (inData),
    .cfg_transpose_i(cfgTranspose),
    .cfg_signed_i   (cfgSigned),
    .cfg_relu_i     (cfgRelu),
    .out_valid_o    (outValid),
    .out_ready_i    (outReady),
    .out_data_o     (outData),
    .out_last_o     (outLast),
    .busy_o         (busy)
  );

  typedef struct {
    logic        t;
    logic        s;
    logic        r;
    logic [63:0] ops;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Streams A then B; cfg inputs flip after the first byte so latching is exercised.
  task automatic applyStimulus(input logic t, input logic s, input logic r, input logic [63:0] ops);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      inValid      = 1'b1;
      inData       = ops[63-8*i -: 8];
      cfgTranspose = (i == 0) ? t : ~t;
      cfgSigned    = (i == 0) ? s : ~s;
      cfgRelu      = (i == 0) ? r : ~r;
    end
    @(negedge clk);
    inValid = 1'b0;
    inData  = 8'h00;
  endtask

  task automatic drainResult(input logic [63:0] exp, input int stallAt);
    int lat;
    lat = 1;
    outReady = 1'b1;
    while (!outValid && lat < 20) begin
      checkOutput("busy_compute", {31'b0, busy}, 32'd1);
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", lat, 32'd3);
    for (int b = 0; b < 8; b++) begin
      if (!outValid) begin
        checkOutput("out_valid_drain", {31'b0, outValid}, 32'd1);
        return;
      end
      if (b == stallAt) begin
        outReady = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checkOutput("stall_data", {24'b0, outData}, {24'b0, exp[63-8*b -: 8]});
          checkOutput("stall_valid", {31'b0, outValid}, 32'd1);
          checkOutput("stall_in_ready", {31'b0, inReady}, 32'd0);
        end
        outReady = 1'b1;
      end
      checkOutput("out_data", {24'b0, outData}, {24'b0, exp[63-8*b -: 8]});
      checkOutput("out_last", {31'b0, outLast}, {31'b0, (b == 7)});
      checkOutput("in_ready_drain", {31'b0, inReady}, 32'd0);
      @(negedge clk);
    end
    checkOutput("back_to_load", {30'b0, inReady, outValid}, 32'd2);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 64'h01020304_05060708, 64'h0013_0016_002B_0032};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 64'h01020304_05060708, 64'h0011_0017_0027_0035};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 64'hFF000001_01000001, 64'h0000_0000_0000_0001};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 64'hFF000001_01000001, 64'hFFFF_0000_0000_0001};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 64'h80808080_80808080, 64'h7FFF_7FFF_7FFF_7FFF};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 64'hFF000001_01000001, 64'h00FF_0000_0000_0001};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 64'h80808080_7F7F7F7F, 64'h8100_8100_8100_8100};

    rst = 1'b1; clear = 1'b0; inValid = 1'b0; inData = 8'h00;
    cfgTranspose = 1'b0; cfgSigned = 1'b0; cfgRelu = 1'b0; outReady = 1'b0;
    #1;
    checkOutput("reset_in_ready", {31'b0, inReady}, 32'd1);
    checkOutput("reset_out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("reset_out_data", {24'b0, outData}, 32'd0);
    checkOutput("reset_out_last", {31'b0, outLast}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      $display("[TB] vector %0d", v);
      applyStimulus(vecs[v].t, vecs[v].s, vecs[v].r, vecs[v].ops);
      drainResult(vecs[v].exp, -1);
    end

    $display("[TB] backpressure");
    applyStimulus(1'b0, 1'b0, 1'b0, vecs[0].ops);
    drainResult(vecs[0].exp, 3);

    $display("[TB] clear after partial load");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      inValid = 1'b1;
      inData  = 8'hA0 + 8'(i);
    end
    @(negedge clk);
    clear = 1'b1;
    inData = 8'h77;
    @(negedge clk);
    clear = 1'b0;
    inValid = 1'b0;
    checkOutput("clear_in_ready", {31'b0, inReady}, 32'd1);
    checkOutput("clear_busy", {31'b0, busy}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, vecs[0].ops);
    drainResult(vecs[0].exp, -1);

    $display("[TB] reset mid-drain");
    applyStimulus(1'b0, 1'b0, 1'b0, vecs[0].ops);
    outReady = 1'b1;
    for (int c = 0; c < 20 && !outValid; c++) @(negedge clk);
    checkOutput("pre_reset_valid", {31'b0, outValid}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_valid", {31'b0, outValid}, 32'd0);
    checkOutput("async_reset_ready", {31'b0, inReady}, 32'd1);
    checkOutput("async_reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("async_reset_data", {24'b0, outData}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("post_reset_idle", {30'b0, outValid, busy}, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, vecs[0].ops);
    drainResult(vecs[0].exp, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpu_matmul_engine.md
TPU_MATMUL_ENGINE -- requirements
Module: tpu_matmul_engine

Interface
REQ-001 Parameter N, default 2, sets the square matrix dimension; legal range 2..4.
REQ-002 Parameter DW, default 8, sets the operand width; fixed at 8 (byte-serial bus).
REQ-003 Parameter OUT_W, default 16, sets the result width; must be a multiple of 8, 16..32.
REQ-004 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, is an asynchronous, active-high reset.
REQ-006 Port clear, input, 1, is a synchronous abort that returns the block to LOAD.
REQ-007 Port in_valid, input, 1, means in_data holds an operand byte.
REQ-008 Port in_ready, output, 1, means the block accepts a byte this cycle.
REQ-009 Port in_data, input, 8, carries the operand byte.
REQ-010 Port cfg_transpose, input, 1, selects B transposed.
REQ-011 Port cfg_signed, input, 1, selects two's-complement operands.
REQ-012 Port cfg_relu, input, 1, selects ReLU on results.
REQ-013 Port out_valid, output, 1, means out_data holds a result byte.
REQ-014 Port out_ready, input, 1, means the consumer accepts the result byte.
REQ-015 Port out_data, output, 8, carries the result byte.
REQ-016 Port out_last, output, 1, marks the final result byte of a matrix.
REQ-017 Port busy, output, 1, is high in COMPUTE and DRAIN.

Function
REQ-018 The block SHALL implement FSM states LOAD, COMPUTE, DRAIN.
REQ-019 In LOAD, in_ready SHALL be 1 and a byte is accepted when in_valid&&in_ready; in all other states in_ready SHALL be 0.
REQ-020 Accepted bytes SHALL fill A row-major (N*N bytes), then B row-major (N*N bytes).
REQ-021 cfg_* SHALL be latched on acceptance of the first A byte and held until the end of DRAIN.
REQ-022 Acceptance of byte index 2*N*N-1 SHALL move LOAD->COMPUTE on the next edge.
REQ-023 COMPUTE SHALL last exactly N cycles; in cycle k, every C[i][j] += A[i][k]*B'[k][j], where B'=B, or B transposed when cfg_transpose=1.
REQ-024 The accumulator width SHALL be 2*DW+clog2(N)+1 bits; products are sign-extended when cfg_signed=1, zero-extended otherwise; the accumulator never overflows.
REQ-025 After COMPUTE the FSM SHALL enter DRAIN; if the last input byte is accepted in cycle t, out_valid SHALL first be 1 in cycle t+N+1.
REQ-026 Result post-processing SHALL apply ReLU (negative->0, only when cfg_signed=1 and cfg_relu=1), then saturate to the OUT_W signed or unsigned range.
REQ-027 DRAIN SHALL emit C row-major, each element as OUT_W/8 bytes, MSB first.
REQ-028 A byte is transferred when out_valid&&out_ready; while out_valid&&!out_ready, out_data and out_last SHALL hold stable.
REQ-029 out_last SHALL be 1 only on byte N*N*OUT_W/8-1.
REQ-030 Transfer of the last byte SHALL return the FSM to LOAD, with accumulators and byte counters zeroed.
REQ-031 clear=1 SHALL, on that edge, zero all counters and accumulators, drop out_valid, and enter LOAD; clear takes priority over any simultaneous handshake.
REQ-032 clear=1 in LOAD SHALL discard partially loaded bytes; the next accepted byte is A[0][0].

Reset
REQ-033 rst=1 SHALL asynchronously force state=LOAD, all counters, accumulators, operand registers and latched cfg to 0, with outputs in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
REQ-034 Reset asserted mid-COMPUTE or mid-DRAIN SHALL abandon the operation; no partial result appears after release.

Verification
REQ-035 N=2 unsigned: A=1,2,3,4; B=5,6,7,8 -> out bytes 00 13 00 16 00 2B 00 32, out_last on byte 8.
REQ-036 Same operands, cfg_transpose=1 -> 00 11 00 17 00 27 00 35.
REQ-037 Signed+ReLU: A=FF,00,00,01; B=01,00,00,01 -> 00 00 00 00 00 00 00 01; same operands without ReLU -> FF FF 00 00 00 00 00 01.
REQ-038 Saturation: all A and B bytes = FF unsigned -> every element FF FF; all bytes = 80 signed -> every element 7F FF.
REQ-039 Backpressure: out_ready held 0 for 5 cycles mid-DRAIN -> out_data stable, no byte lost or duplicated; in_ready stays 0.
REQ-040 Abort/reset: clear pulsed after 3 bytes in LOAD, and rst pulsed mid-DRAIN -> each time, the next full load produces the REQ-035 result exactly.
